localop_sequencer: RTL and testbench
====================================

# localop_sequencer

Sequencing controller for the shared local map-algebra operator (`LocalCodeOp`). It accepts a raster job over a 4-bit valid/ready input stream: one opcode nibble D per job, then A, B, C nibbles per cell. It drives the operator's operand inputs from registers and captures M and N for each cell. It returns M then N per cell on a 4-bit valid/ready output stream. The operator instance is external, so the same operator can be shared or swapped at the top level.

## Interface
- `LEN_W`, default 8: width of the cell-count field; a job holds 1 to 2^LEN_W−1 cells.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: job start pulse; sampled only in IDLE.
- `cfg_len` in LEN_W: number of cells in the job, sampled with `cfg_start`.
- `in_data` in 4: operand/opcode nibble.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `op_a`, `op_b`, `op_c`, `op_d` out 4 each: registered operands to the operator; D[3:2]=op1, D[1:0]=op2.
- `op_m`, `op_n` in 4 each: combinational operator results.
- `out_data` out 4; `out_valid` out 1; `out_ready` in 1: output handshake.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at job end.

## Operation
- States: IDLE, LOAD_D, LOAD_A, LOAD_B, LOAD_C, EXEC, OUT_M, OUT_N, DONE.
- IDLE: `in_ready`=0, `out_valid`=0.
  - `cfg_start` with `cfg_len`≠0: latch `remaining`=`cfg_len`, go to LOAD_D.
  - `cfg_start` with `cfg_len`=0: go directly to DONE; no data is consumed.
- LOAD_D/A/B/C: `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_data` into `op_d`/`op_a`/`op_b`/`op_c` respectively and advance (D→A→B→C→EXEC).
  - With no handshake, the state holds.
- EXEC: `in_ready`=0. On the edge ending EXEC, capture `op_m`→`m_reg` and `op_n`→`n_reg`, then go to OUT_M.
- OUT_M: `out_valid`=1, `out_data`=`m_reg`. On `out_ready`, go to OUT_N.
- OUT_N: `out_valid`=1, `out_data`=`n_reg`. On `out_ready`:
  - if `remaining`=1, go to DONE;
  - else decrement `remaining` and go to LOAD_A.
- D is loaded once per job. `op_d` is held for every cell of the job and is not reloaded between cells.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `cfg_start` in any state other than IDLE is ignored; it neither restarts nor queues a job.
- `op_*` registers change only on their own load handshake. They hold their last values through IDLE and across jobs.
- Arithmetic width belongs to the operator; this block moves 4-bit values only. `remaining` is LEN_W bits and never underflows, because decrement happens only when `remaining`>1.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE;
  - `op_a`..`op_d`=0, `m_reg`=`n_reg`=0;
  - `remaining`=0;
  - `out_data`=0, `out_valid`=0, `in_ready`=0, `busy`=0, `done`=0.
- Reset mid-job discards all progress. After deassertion the block waits in IDLE for a new `cfg_start`.
- All outputs are registered or decoded from registered state; there is no combinational path from `in_valid` or `out_ready` to any output.
- `in_ready` is state-decoded only (LOAD_x states). `out_valid` is high exactly in OUT_M/OUT_N. Once asserted, `out_valid` and `out_data` stay stable until the handshake completes.
- Latency: the C handshake at edge k puts EXEC in cycle k..k+1; `out_valid` with M is visible after edge k+1.
- Throughput: minimum 6 cycles per cell with no stalls (A, B, C, EXEC, M, N). The first cell adds 1 cycle for D, and `cfg_start` adds 1.
- `done` rises the cycle after the final N handshake. `busy` falls the cycle after `done`.
- After `cfg_start` with `cfg_len`=0: `busy`=1 for one cycle (DONE), with `done`=1 in that same cycle.

## Test plan
- Single cell, no stalls: `cfg_len`=1; stream D=4'b1011, A=3, B=4, C=2 into an operator model.
  - Expect `out_data` M=7 then N=4'hE.
  - Expect `done` one cycle after the N handshake, and 7 cycles from `cfg_start` to the first `out_valid`.
- Multi-cell, D once: `cfg_len`=3; D=4'b0001 (AND then OR); cells (F,3,8), (5,6,0), (A,A,1).
  - Expect output pairs (3,B), (4,4), (A,B).
  - `op_d` stays 1 throughout; exactly 10 input handshakes occur.
- Backpressure, both sides:
  - Randomly deassert `in_valid` and `out_ready` on the single-cell test.
  - Results are unchanged; `out_data` is stable while `out_valid` && !`out_ready`; no nibble is dropped or duplicated.
- Zero length and ignored start:
  - `cfg_len`=0 gives `done` the next cycle with no `in_ready`.
  - A `cfg_start` pulsed mid-job does not alter the `remaining` count or the outputs.
- Reset mid-operation: assert `rst_n`=0 during OUT_M.
  - All outputs reach reset values immediately (asynchronously), and the block is in IDLE.
  - A following single-cell job completes correctly.

Source files
------------

// File: rtl/localop_sequencer_if.sv
// Stream bundle between the sequencer and its environment:
// a 4-bit operand/opcode input stream and a 4-bit result output stream.
interface localop_sequencer_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Sequencer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/localop_sequencer.sv
// Sequencer for an external local map-algebra operator.
// Per job: one opcode nibble D, then A, B, C per cell. The operands are held
// in registers that drive the operator. M and N are captured and streamed out.
module localop_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    localop_sequencer_if.slave io,
    output logic [3:0]       op_a,
    output logic [3:0]       op_b,
    output logic [3:0]       op_c,
    output logic [3:0]       op_d,
    input  logic [3:0]       op_m,
    input  logic [3:0]       op_n,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE, LOAD_D, LOAD_A, LOAD_B, LOAD_C, EXEC, OUT_M, OUT_N, DONE
    } state_t;

    // Operand bank feeding the operator; D persists for the whole job.
    typedef struct packed {
        logic [3:0] d;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } operand_t;

    state_t           state, state_nxt;
    operand_t         opr;
    logic [3:0]       m_reg, n_reg;
    logic [LEN_W-1:0] remaining;
    logic             in_hs, out_hs, last_cell, len_zero;

    assign in_hs     = io.in_valid && io.in_ready;
    assign out_hs    = io.out_valid && io.out_ready;
    assign last_cell = (remaining == LEN_W'(1));
    assign len_zero  = (cfg_len == '0);

    assign op_a = opr.a;
    assign op_b = opr.b;
    assign op_c = opr.c;
    assign op_d = opr.d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; cfg_start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = len_zero ? DONE : LOAD_D;
            LOAD_D:  if (in_hs) state_nxt = LOAD_A;
            LOAD_A:  if (in_hs) state_nxt = LOAD_B;
            LOAD_B:  if (in_hs) state_nxt = LOAD_C;
            LOAD_C:  if (in_hs) state_nxt = EXEC;
            EXEC:    state_nxt = OUT_M;
            OUT_M:   if (out_hs) state_nxt = OUT_N;
            OUT_N:   if (out_hs) state_nxt = last_cell ? DONE : LOAD_A;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and result registers,
    // so nothing here depends combinationally on in_valid or out_ready.
    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_data  = 4'h0;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            LOAD_D, LOAD_A, LOAD_B, LOAD_C: io.in_ready = 1'b1;
            OUT_M: begin
                io.out_valid = 1'b1;
                io.out_data  = m_reg;
            end
            OUT_N: begin
                io.out_valid = 1'b1;
                io.out_data  = n_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand loads: each register moves only on its own input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr <= '0;
        end else if (in_hs) begin
            case (state)
                LOAD_D:  opr.d <= io.in_data;
                LOAD_A:  opr.a <= io.in_data;
                LOAD_B:  opr.b <= io.in_data;
                LOAD_C:  opr.c <= io.in_data;
                default: ;
            endcase
        end
    end

    // Result capture at the end of EXEC; held stable through OUT_M/OUT_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= 4'h0;
            n_reg <= 4'h0;
        end else if (state == EXEC) begin
            m_reg <= op_m;
            n_reg <= op_n;
        end
    end

    // Cell counter: loaded at job start, decremented only when more cells
    // follow, so it never wraps below one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (state == IDLE && cfg_start && !len_zero) begin
            remaining <= cfg_len;
        end else if (state == OUT_N && out_hs && !last_cell) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_localop_sequencer.sv
// Self-checking bench for localop_sequencer with a behavioural operator model
// (00 AND, 01 OR, 10 ADD, 11 MUL, all mod 16; M = op1(A,B), N = op2(M,C)).
module tb_localop_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_len = 8'd0;
    logic [3:0] op_a, op_b, op_c, op_d, op_m, op_n;
    logic       busy, done;

    localop_sequencer_if bus();

    localop_sequencer #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .io(bus), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .op_m(op_m), .op_n(op_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu(input logic [1:0] sel, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        case (sel)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x + y;
            default: begin p = x * y; return p[3:0]; end
        endcase
    endfunction

    // External operator model.
    assign op_m = alu(op_d[3:2], op_a, op_b);
    assign op_n = alu(op_d[1:0], op_m, op_c);

    int total = 0;
    int bad = 0;

    logic [3:0] in_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] opd_q[$];
    logic [3:0] cur_d;
    int in_stall = 0;
    int out_stall = 0;
    int unstable = 0;
    bit timed_out = 0;

    // Cycle monitor.
    logic mon_clr = 1'b0;
    int cyc, in_hs, out_hs, start_cyc, first_ov, last_out, done_cyc, done_cnt, ir_seen;
    logic busy_at_done, busy_after;

    always @(posedge clk) begin
        if (mon_clr) begin
            cyc <= 0; in_hs <= 0; out_hs <= 0; start_cyc <= -1; first_ov <= -1;
            last_out <= -1; done_cyc <= -1; done_cnt <= 0; ir_seen <= 0;
            busy_at_done <= 1'b0; busy_after <= 1'b1;
        end else begin
            cyc <= cyc + 1;
            if (bus.in_valid && bus.in_ready) in_hs <= in_hs + 1;
            if (bus.out_valid && bus.out_ready) begin
                out_hs <= out_hs + 1;
                last_out <= cyc;
            end
            if (bus.out_valid && first_ov < 0) first_ov <= cyc;
            if (cfg_start && !busy && start_cyc < 0) start_cyc <= cyc;
            if (bus.in_ready) ir_seen <= ir_seen + 1;
            if (done) begin
                done_cyc <= cyc;
                done_cnt <= done_cnt + 1;
                busy_at_done <= busy;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after <= busy;
        end
    end

    task automatic clear_job();
        in_q.delete(); exp_q.delete(); got_q.delete(); opd_q.delete();
    endtask

    task automatic new_job(input logic [3:0] d);
        clear_job();
        cur_d = d;
        in_q.push_back(d);
    endtask

    // Reference: push operands and the results the operator rules predict.
    task automatic add_cell(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] m, n;
        m = alu(cur_d[3:2], a, b);
        n = alu(cur_d[1:0], m, c);
        in_q.push_back(a); in_q.push_back(b); in_q.push_back(c);
        exp_q.push_back(m); exp_q.push_back(n);
    endtask

    task automatic start_job(input int len);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        timed_out = 0; unstable = 0;
        cfg_start = 1'b1; cfg_len = 8'(len);
    endtask

    task automatic feed();
        int idx = 0;
        int guard = 0;
        bit v;
        while (idx < in_q.size() && guard < 3000) begin
            v = ($urandom_range(99) >= in_stall);
            bus.in_valid = v;
            bus.in_data = v ? in_q[idx] : 4'($urandom);
            if (v && bus.in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        if (idx < in_q.size()) timed_out = 1;
    endtask

    task automatic collect();
        int guard = 0;
        bit r;
        bit hold = 0;
        logic [3:0] held;
        while (got_q.size() < exp_q.size() && guard < 3000) begin
            r = ($urandom_range(99) >= out_stall);
            bus.out_ready = r;
            if (hold && (!bus.out_valid || bus.out_data !== held)) unstable++;
            if (bus.out_valid) begin
                if (r) begin
                    got_q.push_back(bus.out_data);
                    opd_q.push_back(op_d);
                    hold = 0;
                end else begin
                    hold = 1;
                    held = bus.out_data;
                end
            end else begin
                hold = 0;
            end
            @(negedge clk);
            guard++;
        end
        bus.out_ready = 1'b0;
        if (got_q.size() < exp_q.size()) timed_out = 1;
    endtask

    task automatic run_job(input int len, input bit inject);
        int g = 0;
        start_job(len);
        fork
            feed();
            collect();
            begin
                @(negedge clk); cfg_start = 1'b0;
                if (inject) begin
                    repeat (6) @(negedge clk);
                    cfg_start = 1'b1; cfg_len = 8'd7;
                    @(negedge clk); cfg_start = 1'b0;
                end
            end
        join
        while (done_cnt == 0 && g < 100) begin @(negedge clk); g++; end
        if (done_cnt == 0) timed_out = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_handshake: got %b%b want 00", bus.in_ready, bus.out_valid); end
        total++; if (bus.out_data !== 4'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        total++; if ({op_a, op_b, op_c, op_d} !== 16'h0) begin bad++; $display("FAIL reset_ops: got %h want 0000", {op_a, op_b, op_c, op_d}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
    endtask

    task automatic test_single_cell();
        in_stall = 0; out_stall = 0;
        new_job(4'b1011); add_cell(4'd3, 4'd4, 4'd2);
        run_job(1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL single_timeout: got 1 want 0"); end
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL single_count: got %0d want 2", got_q.size()); end
        total++; if (got_q[0] !== 4'h7) begin bad++; $display("FAIL single_m: got %h want 7", got_q[0]); end
        total++; if (got_q[1] !== 4'hE) begin bad++; $display("FAIL single_n: got %h want e", got_q[1]); end
        // cfg_start cycle counted as cycle 1, first out_valid in cycle 7.
        total++; if (first_ov - start_cyc != 6) begin bad++; $display("FAIL single_latency: got %0d want 6", first_ov - start_cyc); end
        total++; if (done_cyc != last_out + 1) begin bad++; $display("FAIL single_done_time: got %0d want %0d", done_cyc, last_out + 1); end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", busy_after); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_multi_cell();
        logic [3:0] want[6] = '{4'h3, 4'hB, 4'h4, 4'h4, 4'hA, 4'hB};
        in_stall = 0; out_stall = 0;
        new_job(4'b0001);
        add_cell(4'hF, 4'h3, 4'h8); add_cell(4'h5, 4'h6, 4'h0); add_cell(4'hA, 4'hA, 4'h1);
        run_job(3, 0);
        total++; if (timed_out) begin bad++; $display("FAIL multi_timeout: got 1 want 0"); end
        for (int i = 0; i < 6; i++) begin
            total++; if (got_q[i] !== want[i]) begin bad++; $display("FAIL multi_out%0d: got %h want %h", i, got_q[i], want[i]); end
        end
        total++; if (in_hs != 10) begin bad++; $display("FAIL multi_in_hs: got %0d want 10", in_hs); end
        for (int i = 0; i < opd_q.size(); i++) begin
            total++; if (opd_q[i] !== 4'h1) begin bad++; $display("FAIL multi_op_d%0d: got %h want 1", i, opd_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        in_stall = 40; out_stall = 40;
        for (int k = 0; k < 4; k++) begin
            new_job(4'b1011); add_cell(4'd3, 4'd4, 4'd2);
            run_job(1, 0);
            total++; if (timed_out) begin bad++; $display("FAIL bp_timeout%0d: got 1 want 0", k); end
            total++; if (got_q[0] !== 4'h7 || got_q[1] !== 4'hE) begin bad++; $display("FAIL bp_result%0d: got %h%h want 7e", k, got_q[0], got_q[1]); end
            total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable%0d: got %0d changes want 0", k, unstable); end
            total++; if (in_hs != 4 || out_hs != 2) begin bad++; $display("FAIL bp_hs%0d: got %0d/%0d want 4/2", k, in_hs, out_hs); end
        end
    endtask

    task automatic test_zero_len();
        clear_job();
        start_job(0);
        bus.in_valid = 1'b1; bus.in_data = 4'h5;
        @(negedge clk); cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (done_cyc - start_cyc != 1) begin bad++; $display("FAIL zero_done_time: got %0d want 1", done_cyc - start_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        total++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b%b want 10", busy_at_done, busy_after); end
        total++; if (ir_seen != 0 || in_hs != 0) begin bad++; $display("FAIL zero_in_ready: got %0d/%0d want 0/0", ir_seen, in_hs); end
    endtask

    task automatic test_ignored_start();
        in_stall = 20; out_stall = 20;
        new_job(4'($urandom));
        for (int i = 0; i < 2; i++) add_cell(4'($urandom), 4'($urandom), 4'($urandom));
        run_job(2, 1);
        total++; if (timed_out) begin bad++; $display("FAIL ign_timeout: got 1 want 0"); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ign_out%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0 || done_cnt != 1) begin bad++; $display("FAIL ign_no_queue: busy %b dones %0d want 0 1", busy, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        in_stall = 0; out_stall = 0;
        new_job(4'b1011); add_cell(4'd3, 4'd4, 4'd2);
        bus.out_ready = 1'b0;
        start_job(1);
        @(negedge clk); cfg_start = 1'b0;
        feed();
        while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_reach_out_m: got %b want 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_async_hs: got %b%b want 00", bus.out_valid, bus.in_ready); end
        total++; if (bus.out_data !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_async_out: got %h %b %b want 0 0 0", bus.out_data, busy, done); end
        total++; if ({op_a, op_b, op_c, op_d} !== 16'h0) begin bad++; $display("FAIL rst_async_ops: got %h want 0000", {op_a, op_b, op_c, op_d}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        new_job(4'b0110); add_cell(4'h9, 4'h6, 4'h3);
        run_job(1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL rst_job_timeout: got 1 want 0"); end
        total++; if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin bad++; $display("FAIL rst_job_result: got %h%h want %h%h", got_q[0], got_q[1], exp_q[0], exp_q[1]); end
    endtask

    task automatic test_random();
        int len;
        in_stall = 25; out_stall = 25;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 4);
            new_job(4'($urandom));
            for (int i = 0; i < len; i++) add_cell(4'($urandom), 4'($urandom), 4'($urandom));
            run_job(len, 0);
            total++; if (timed_out) begin bad++; $display("FAIL rand%0d_timeout: got 1 want 0", k); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_out%0d: got %h want %h", k, i, got_q[i], exp_q[i]); end
            end
            total++; if (done_cyc != last_out + 1) begin bad++; $display("FAIL rand%0d_done_time: got %0d want %0d", k, done_cyc, last_out + 1); end
            total++; if (unstable != 0) begin bad++; $display("FAIL rand%0d_stable: got %0d want 0", k, unstable); end
        end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_multi_cell();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
